// File: rtl/prbs16_checker_if.sv
`default_nettype none
// ============================================================================
// Module   : prbs16_checker_if
// Purpose  : Sample stream and status bundle between BIST source and checker.
// Revision : 1.0  initial release
// ============================================================================
interface prbs16_checker_if;
  logic        in_valid;
  logic [15:0] in_data;
  logic        clear_counts;
  logic        locked;
  logic        err_pulse;
  logic [15:0] err_count;
  logic [31:0] word_count;
  logic        stuck;

  modport master (
    output in_valid, in_data, clear_counts,
    input  locked, err_pulse, err_count, word_count, stuck
  );

  modport slave (
    input  in_valid, in_data, clear_counts,
    output locked, err_pulse, err_count, word_count, stuck
  );
endinterface
`default_nettype wire

// File: rtl/prbs16_checker.sv
`default_nettype none
// ============================================================================
// Module   : prbs16_checker
// Purpose  : Self-synchronising checker for the 16-bit Fibonacci LFSR stream.
// Revision : 1.0  initial release
// ============================================================================
module prbs16_checker #(
  parameter int LOCK_CNT   = 4,
  parameter int UNLOCK_CNT = 8,
  parameter int STUCK_CNT  = 16
) (
  input  wire logic            clk,
  input  wire logic            reset,
  prbs16_checker_if.slave      s_if
);

  localparam logic [3:0] c_LOCK_CNT   = 4'(LOCK_CNT);
  localparam logic [3:0] c_UNLOCK_CNT = 4'(UNLOCK_CNT);
  localparam logic [7:0] c_STUCK_CNT  = 8'(STUCK_CNT);

  typedef enum logic [1:0] {
    ST_UNLOCKED = 2'd0,
    ST_LOCKING  = 2'd1,
    ST_LOCKED   = 2'd2
  } state_t;

  function automatic logic [15:0] f_nxt(input logic [15:0] x);
    return {x[14:0], x[15] ^ x[13] ^ x[12] ^ x[10]};
  endfunction

  state_t      r_state;
  logic [15:0] r_pred;
  logic [3:0]  r_match_cnt;
  logic [3:0]  r_miss_cnt;
  logic [7:0]  r_zero_cnt;
  logic        r_locked;
  logic        r_err_pulse;
  logic [15:0] r_err_count;
  logic [31:0] r_word_count;
  logic        r_stuck;

  logic        w_zero;
  logic        w_hit;
  logic        w_err_inc;
  logic        w_word_inc;
  logic [15:0] w_err_base;
  logic [31:0] w_word_base;
  logic [15:0] w_err_next;
  logic [31:0] w_word_next;
  logic [7:0]  w_zero_next;

  // Clear is applied before the increment so a colliding word counts as 1.
  always_comb begin
    w_zero      = (s_if.in_data == 16'h0000);
    w_hit       = (s_if.in_data == r_pred);
    w_err_inc   = s_if.in_valid && (r_state == ST_LOCKED) && !w_hit;
    w_word_inc  = s_if.in_valid && (r_state == ST_LOCKED);
    w_err_base  = s_if.clear_counts ? 16'h0000 : r_err_count;
    w_word_base = s_if.clear_counts ? 32'h0000_0000 : r_word_count;
    w_err_next  = (w_err_inc && (w_err_base != 16'hFFFF)) ? w_err_base + 16'd1 : w_err_base;
    w_word_next = (w_word_inc && (w_word_base != 32'hFFFF_FFFF)) ? w_word_base + 32'd1 : w_word_base;
    if (!w_zero)
      w_zero_next = 8'd0;
    else if (r_zero_cnt == 8'hFF)
      w_zero_next = 8'hFF;
    else
      w_zero_next = r_zero_cnt + 8'd1;
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      r_state      <= ST_UNLOCKED;
      r_pred       <= 16'h0000;
      r_match_cnt  <= 4'd0;
      r_miss_cnt   <= 4'd0;
      r_zero_cnt   <= 8'd0;
      r_locked     <= 1'b0;
      r_err_pulse  <= 1'b0;
      r_err_count  <= 16'h0000;
      r_word_count <= 32'h0000_0000;
      r_stuck      <= 1'b0;
    end else begin
      r_err_pulse  <= w_err_inc;
      r_err_count  <= w_err_next;
      r_word_count <= w_word_next;
      if (s_if.in_valid) begin
        r_zero_cnt <= w_zero_next;
        r_stuck    <= (w_zero_next >= c_STUCK_CNT);
        case (r_state)
          ST_UNLOCKED: begin
            if (!w_zero) begin
              r_pred      <= f_nxt(s_if.in_data);
              r_match_cnt <= 4'd0;
              r_state     <= ST_LOCKING;
            end
          end
          ST_LOCKING: begin
            if (w_hit) begin
              r_match_cnt <= r_match_cnt + 4'd1;
              r_pred      <= f_nxt(s_if.in_data);
              if ((r_match_cnt + 4'd1) >= c_LOCK_CNT) begin
                r_state    <= ST_LOCKED;
                r_locked   <= 1'b1;
                r_miss_cnt <= 4'd0;
              end
            end else if (!w_zero) begin
              r_pred      <= f_nxt(s_if.in_data);
              r_match_cnt <= 4'd0;
            end else begin
              r_match_cnt <= 4'd0;
              r_state     <= ST_UNLOCKED;
            end
          end
          ST_LOCKED: begin
            // Free-run the prediction so one bad word costs exactly one error.
            r_pred <= f_nxt(r_pred);
            if (w_hit) begin
              r_miss_cnt <= 4'd0;
            end else if ((r_miss_cnt + 4'd1) >= c_UNLOCK_CNT) begin
              r_miss_cnt <= 4'd0;
              r_locked   <= 1'b0;
              r_state    <= ST_UNLOCKED;
            end else begin
              r_miss_cnt <= r_miss_cnt + 4'd1;
            end
          end
          default: begin
            r_state  <= ST_UNLOCKED;
            r_locked <= 1'b0;
          end
        endcase
      end
    end
  end

  assign s_if.locked     = r_locked;
  assign s_if.err_pulse  = r_err_pulse;
  assign s_if.err_count  = r_err_count;
  assign s_if.word_count = r_word_count;
  assign s_if.stuck      = r_stuck;

endmodule
`default_nettype wire

// File: tb/tb_prbs16_checker.sv
`default_nettype none
// ============================================================================
// Module   : tb_prbs16_checker
// Purpose  : Randomised and directed self-checking bench for prbs16_checker.
// Revision : 1.0  initial release
// ============================================================================
`timescale 1ns/1ps
module tb_prbs16_checker;

  logic clk = 1'b0;
  logic reset = 1'b1;
  int   n_tests = 0;
  int   n_fail  = 0;

  prbs16_checker_if bus();

  prbs16_checker #(.LOCK_CNT(4), .UNLOCK_CNT(8), .STUCK_CNT(16)) dut (
    .clk   (clk),
    .reset (reset),
    .s_if  (bus)
  );

  always #5 clk = ~clk;

  // Reference model: tracks the stream history as plain counters.
  logic [15:0] m_pred;
  bit          m_seeded, m_locked, m_pulse, m_stuck;
  int          m_good, m_bad, m_zeros, m_err;
  logic [31:0] m_words;
  logic [15:0] gen;

  function automatic logic [15:0] lfsr_next(input logic [15:0] x);
    logic fb;
    fb = ^(x & 16'hB400);
    return (x << 1) | {15'd0, fb};
  endfunction

  task automatic check_val(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_tests++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h, expected %0h", tag, obs, exp);
    end
  endtask

  task automatic model_reset();
    m_pred = '0; m_seeded = 0; m_locked = 0; m_pulse = 0; m_stuck = 0;
    m_good = 0; m_bad = 0; m_zeros = 0; m_err = 0; m_words = '0;
  endtask

  task automatic model_step(input logic v, input logic [15:0] d, input logic clr);
    m_pulse = 0;
    if (clr) begin
      m_err = 0;
      m_words = '0;
    end
    if (v) begin
      m_zeros = (d == 0) ? ((m_zeros < 255) ? m_zeros + 1 : 255) : 0;
      m_stuck = (m_zeros >= 16);
      if (m_locked) begin
        if (m_words != 32'hFFFF_FFFF) m_words = m_words + 1;
        if (d != m_pred) begin
          m_pulse = 1;
          if (m_err < 65535) m_err++;
          m_bad++;
          if (m_bad >= 8) begin
            m_locked = 0; m_seeded = 0; m_bad = 0;
          end
        end else begin
          m_bad = 0;
        end
        m_pred = lfsr_next(m_pred);
      end else if (m_seeded && d == m_pred) begin
        m_good++;
        m_pred = lfsr_next(d);
        if (m_good >= 4) begin
          m_locked = 1; m_bad = 0;
        end
      end else if (d != 0) begin
        m_seeded = 1; m_good = 0; m_pred = lfsr_next(d);
      end else begin
        m_seeded = 0;
      end
    end
  endtask

  task automatic check_all(input string ph);
    check_val({ph, ".locked"},     {31'd0, bus.locked},     {31'd0, m_locked});
    check_val({ph, ".err_pulse"},  {31'd0, bus.err_pulse},  {31'd0, m_pulse});
    check_val({ph, ".err_count"},  {16'd0, bus.err_count},  32'(m_err));
    check_val({ph, ".word_count"}, bus.word_count,          m_words);
    check_val({ph, ".stuck"},      {31'd0, bus.stuck},      {31'd0, m_stuck});
  endtask

  task automatic send(input string ph, input logic v, input logic [15:0] d, input logic clr);
    @(negedge clk);
    bus.in_valid = v; bus.in_data = d; bus.clear_counts = clr;
    @(posedge clk);
    model_step(v, d, clr);
    #1;
    check_all(ph);
  endtask

  task automatic do_reset(input logic v, input logic [15:0] d);
    @(negedge clk);
    reset = 1'b1; bus.in_valid = v; bus.in_data = d; bus.clear_counts = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    model_reset();
    check_all("reset");
    @(negedge clk);
    reset = 1'b0; bus.in_valid = 1'b0;
  endtask

  task automatic send_good(input string ph, input int n);
    for (int k = 0; k < n; k++) begin
      send(ph, 1'b1, gen, 1'b0);
      gen = lfsr_next(gen);
    end
  endtask

  initial begin
    bus.in_valid = 1'b0; bus.in_data = '0; bus.clear_counts = 1'b0;
    model_reset();
    do_reset(1'b0, 16'h0000);

    // Lock from seed 0001
    gen = 16'h0001;
    send_good("lock", 4);
    check_val("lock.not_yet", {31'd0, bus.locked}, 32'd0);
    send_good("lock", 1);
    check_val("lock.after5", {31'd0, bus.locked}, 32'd1);
    send_good("lock", 3);
    check_val("lock.words", bus.word_count, 32'd3);

    // Single corrupted word
    send("single", 1'b1, gen ^ 16'h0001, 1'b0);
    gen = lfsr_next(gen);
    check_val("single.pulse", {31'd0, bus.err_pulse}, 32'd1);
    send_good("single", 4);
    check_val("single.err", {16'd0, bus.err_count}, 32'd1);
    check_val("single.locked", {31'd0, bus.locked}, 32'd1);

    // Loss of lock and relock
    for (int k = 0; k < 8; k++) begin
      send("loss", 1'b1, 16'hFFFF, 1'b0);
      gen = lfsr_next(gen);
    end
    check_val("loss.unlocked", {31'd0, bus.locked}, 32'd0);
    check_val("loss.err", {16'd0, bus.err_count}, 32'd9);
    send_good("relock", 5);
    check_val("relock.locked", {31'd0, bus.locked}, 32'd1);

    // Stuck-at-zero
    do_reset(1'b0, 16'h0000);
    for (int k = 0; k < 20; k++) send("stuck", 1'b1, 16'h0000, 1'b0);
    check_val("stuck.high", {31'd0, bus.stuck}, 32'd1);
    send("stuck_clr", 1'b1, 16'h1234, 1'b0);
    check_val("stuck.cleared", {31'd0, bus.stuck}, 32'd0);

    // Randomised locked stream with bubbles, errors, zeros and clears
    do_reset(1'b0, 16'h0000);
    gen = 16'(($urandom_range(16'hFFFE, 0)) + 1);
    send_good("rnd_lock", 5);
    for (int k = 0; k < 2500; k++) begin
      int r;
      logic clr;
      r   = $urandom_range(99, 0);
      clr = ($urandom_range(49, 0) == 0);
      if (r < 20) begin
        send("rnd_bubble", 1'b0, 16'($urandom), clr);
      end else if (r < 24) begin
        send("rnd_err", 1'b1, gen ^ (16'h0001 << $urandom_range(15, 0)), clr);
        gen = lfsr_next(gen);
      end else if (r < 25) begin
        send("rnd_zero", 1'b1, 16'h0000, clr);
        gen = lfsr_next(gen);
      end else begin
        send("rnd_good", 1'b1, gen, clr);
        gen = lfsr_next(gen);
      end
    end

    // Saturation: preload counters near their ceilings
    do_reset(1'b0, 16'h0000);
    gen = 16'hACE1;
    send_good("sat_lock", 5);
    force dut.r_err_count  = 16'hFFFE;
    force dut.r_word_count = 32'hFFFF_FFFE;
    #1;
    release dut.r_err_count;
    release dut.r_word_count;
    m_err = 16'hFFFE; m_words = 32'hFFFF_FFFE;
    for (int k = 0; k < 3; k++) begin
      send("sat", 1'b1, ~gen, 1'b0);
      gen = lfsr_next(gen);
      send_good("sat", 1);
    end
    check_val("sat.err", {16'd0, bus.err_count}, 32'h0000_FFFF);
    check_val("sat.words", bus.word_count, 32'hFFFF_FFFF);

    // Clear colliding with an erroring word
    send("collide", 1'b1, gen ^ 16'h8000, 1'b1);
    gen = lfsr_next(gen);
    check_val("collide.err", {16'd0, bus.err_count}, 32'd1);
    check_val("collide.words", bus.word_count, 32'd1);
    send_good("collide", 2);

    // Mid-lock reset with a valid word presented
    do_reset(1'b1, gen);
    check_val("midreset.words", bus.word_count, 32'd0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
`default_nettype wire
